pipe_ctrl: RTL

Pipeline sequencing controller for the Beta pipeline. It sits beside fetch and decode and resolves control transfers: taken BEQ/BNE/JMP, illegal opcodes, external interrupts, reset vectoring and load-use stalls. It drives the PC mux select, the PC enable, and the instruction-register source selects for the fetch→decode and decode→exec registers. All redirects annul wrong-path fetches for a configurable number of cycles.

---
 rtl/pipe_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Beta pipeline sequencing controller: PC mux / PC enable / IR source selects with redirect annulment.
// Optional event counters are built when PIPE_CTRL_PERF_EN is defined; otherwise perf_* read 0.
//
// state   | meaning
// ST_RST  | first cycle after reset release, vector to reset address
// ST_RUN  | normal sequencing: flush, stall, illop, branch, irq, advance
module pipe_ctrl #(
  parameter int unsigned FETCH_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_dec,
  input  logic        op_jmp,
  input  logic        op_beq,
  input  logic        op_bne,
  input  logic        zr,
  input  logic        illop_dec,
  input  logic        sup_dec,
  input  logic        irq,
  output logic [2:0]  pc_sel,
  output logic        pc_en,
  output logic [1:0]  ir_src_if,
  output logic [1:0]  ir_src_dec,
  output logic        irq_ack,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_redirect,
  output logic [31:0] perf_irq
);

  localparam logic [2:0] PC_SEL_PC4   = 3'd0;
  localparam logic [2:0] PC_SEL_BR    = 3'd1;
  localparam logic [2:0] PC_SEL_JMP   = 3'd2;
  localparam logic [2:0] PC_SEL_ILLOP = 3'd3;
  localparam logic [2:0] PC_SEL_IRQ   = 3'd4;
  localparam logic [2:0] PC_SEL_RESET = 3'd5;

  localparam logic [1:0] IR_SRC_DATA   = 2'd0;
  localparam logic [1:0] IR_SRC_NOP    = 2'd1;
  localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;

  localparam logic [2:0] FLUSH_FULL  = 3'(FETCH_LAT);
  localparam logic [2:0] FLUSH_REDIR = 3'(FETCH_LAT - 1);

  typedef enum logic {ST_RST, ST_RUN} state_t;

  state_t     st, st_nxt;
  logic [2:0] flush_cnt, flush_nxt;
  logic       irq_pend;
  logic       irq_take;
  logic       ev_stall;
  logic       ev_redir;
  logic       taken;

  assign taken = op_jmp | (op_beq & zr) | (op_bne & ~zr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_RST;
      flush_cnt <= 3'd0;
      irq_pend  <= 1'b0;
    end else begin
      st        <= st_nxt;
      flush_cnt <= flush_nxt;
      if (irq)
        irq_pend <= 1'b1;
      else if (irq_take)
        irq_pend <= 1'b0;
    end
  end

  always_comb begin
    st_nxt     = st;
    flush_nxt  = flush_cnt;
    pc_sel     = PC_SEL_PC4;
    pc_en      = 1'b1;
    ir_src_if  = IR_SRC_DATA;
    ir_src_dec = IR_SRC_DATA;
    irq_ack    = 1'b0;
    irq_take   = 1'b0;
    ev_stall   = 1'b0;
    ev_redir   = 1'b0;
    if (rst) begin
      // Mealy outputs must reflect reset immediately, not at the next edge.
      pc_sel     = PC_SEL_RESET;
      pc_en      = 1'b0;
      ir_src_if  = IR_SRC_NOP;
      ir_src_dec = IR_SRC_NOP;
    end else begin
      case (st)
        ST_RST: begin
          pc_sel     = PC_SEL_RESET;
          ir_src_if  = IR_SRC_NOP;
          ir_src_dec = IR_SRC_NOP;
          st_nxt     = ST_RUN;
          flush_nxt  = FLUSH_FULL;
        end
        ST_RUN: begin
          if (flush_cnt != 3'd0) begin
            ir_src_if  = IR_SRC_NOP;
            ir_src_dec = IR_SRC_NOP;
            flush_nxt  = flush_cnt - 3'd1;
          end else if (stall_dec) begin
            pc_en    = 1'b0;
            ev_stall = 1'b1;
          end else if (illop_dec) begin
            pc_sel     = PC_SEL_ILLOP;
            ir_src_if  = IR_SRC_NOP;
            ir_src_dec = IR_SRC_EXCEPT;
            flush_nxt  = FLUSH_REDIR;
            ev_redir   = 1'b1;
          end else if (taken) begin
            pc_sel    = op_jmp ? PC_SEL_JMP : PC_SEL_BR;
            ir_src_if = IR_SRC_NOP;
            flush_nxt = FLUSH_REDIR;
            ev_redir  = 1'b1;
          end else if (irq_pend && !sup_dec && !(op_jmp || op_beq || op_bne)) begin
            pc_sel     = PC_SEL_IRQ;
            ir_src_if  = IR_SRC_NOP;
            ir_src_dec = IR_SRC_EXCEPT;
            irq_ack    = 1'b1;
            irq_take   = 1'b1;
            flush_nxt  = FLUSH_REDIR;
            ev_redir   = 1'b1;
          end
        end
        default: st_nxt = ST_RST;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall    <= 32'd0;
      perf_redirect <= 32'd0;
      perf_irq      <= 32'd0;
    end else begin
      if (ev_stall) perf_stall    <= perf_stall + 32'd1;
      if (ev_redir) perf_redirect <= perf_redirect + 32'd1;
      if (irq_ack)  perf_irq      <= perf_irq + 32'd1;
    end
  end
`else
  logic perf_unused;
  assign perf_unused   = ev_stall ^ ev_redir;
  assign perf_stall    = 32'd0;
  assign perf_redirect = 32'd0;
  assign perf_irq      = 32'd0;
`endif

endmodule
